// File: rtl/glitc_intercom_align.sv
// Training and word-alignment controller for the GLITC intercom receive path.
// Each channel hunts for TRAIN_PATTERN by bitslipping, then holds a sticky lock or fail flag.
module glitc_intercom_align #(
    parameter int          NUM_CH        = 2,
    parameter logic [3:0]  TRAIN_PATTERN = 4'b1000,
    parameter int          MATCH_COUNT   = 16,
    parameter int          BITSLIP_WAIT  = 8,
    parameter int          MAX_SLIPS     = 7
) (
    input  logic                  sysclk_i,
    input  logic                  rst_n_i,
    input  logic                  train_i,
    input  logic [4*NUM_CH-1:0]   data_i,
    output logic [4*NUM_CH-1:0]   data_o,
    output logic [NUM_CH-1:0]     bitslip_o,
    output logic [NUM_CH-1:0]     locked_o,
    output logic [NUM_CH-1:0]     fail_o,
    output logic                  all_locked_o,
    output logic [4*NUM_CH-1:0]   slip_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCKED, S_FAIL
    } state_t;

    localparam logic [7:0] MC_LAST   = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] WAIT_INIT = 8'(BITSLIP_WAIT - 1);
    localparam logic [3:0] SLIP_MAX  = 4'(MAX_SLIPS);

    logic [4*NUM_CH-1:0] data_q;
    logic                train_q;
    logic                train_start;
    logic [NUM_CH-1:0]   match;

    state_t     state_q [NUM_CH];
    state_t     state_d [NUM_CH];
    logic [7:0] mcnt_q  [NUM_CH];
    logic [7:0] mcnt_d  [NUM_CH];
    logic [7:0] wcnt_q  [NUM_CH];
    logic [7:0] wcnt_d  [NUM_CH];
    logic [3:0] slip_q  [NUM_CH];
    logic [3:0] slip_d  [NUM_CH];

    // Input stage: data is a plain retiming register with no reset.
    always_ff @(posedge sysclk_i) begin
        data_q <= data_i;
    end

    assign train_start = train_i & ~train_q;

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            train_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= S_IDLE;
                mcnt_q[k]  <= '0;
                wcnt_q[k]  <= '0;
                slip_q[k]  <= '0;
            end
        end else begin
            train_q <= train_i;
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_d[k];
                mcnt_q[k]  <= mcnt_d[k];
                wcnt_q[k]  <= wcnt_d[k];
                slip_q[k]  <= slip_d[k];
            end
        end
    end

    // Per-channel next state; a training restart overrides every other transition.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            mcnt_d[k]  = mcnt_q[k];
            wcnt_d[k]  = wcnt_q[k];
            slip_d[k]  = slip_q[k];
            if (train_start) begin
                state_d[k] = S_CHECK;
                mcnt_d[k]  = '0;
                wcnt_d[k]  = '0;
                slip_d[k]  = '0;
            end else begin
                case (state_q[k])
                    S_CHECK: begin
                        if (!train_i) begin
                            state_d[k] = S_IDLE;
                        end else if (match[k]) begin
                            if (mcnt_q[k] == MC_LAST) state_d[k] = S_LOCKED;
                            else                      mcnt_d[k]  = mcnt_q[k] + 8'd1;
                        end else if (slip_q[k] == SLIP_MAX) begin
                            state_d[k] = S_FAIL;
                        end else begin
                            state_d[k] = S_SLIP;
                            mcnt_d[k]  = '0;
                        end
                    end
                    S_SLIP: begin
                        slip_d[k] = slip_q[k] + 4'd1;
                        if (!train_i) begin
                            state_d[k] = S_IDLE;
                        end else begin
                            state_d[k] = S_WAIT;
                            wcnt_d[k]  = WAIT_INIT;
                        end
                    end
                    S_WAIT: begin
                        if (!train_i) begin
                            state_d[k] = S_IDLE;
                        end else if (wcnt_q[k] == 8'd0) begin
                            state_d[k] = S_CHECK;
                            mcnt_d[k]  = '0;
                        end else begin
                            wcnt_d[k]  = wcnt_q[k] - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode straight from the state register, so bitslip is glitch-free.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign match[g]              = (data_q[4*g +: 4] == TRAIN_PATTERN);
        assign bitslip_o[g]          = (state_q[g] == S_SLIP);
        assign locked_o[g]           = (state_q[g] == S_LOCKED);
        assign fail_o[g]             = (state_q[g] == S_FAIL);
        assign slip_count_o[4*g +: 4] = slip_q[g];
    end

    assign data_o       = data_q;
    assign all_locked_o = &locked_o;

endmodule

// File: tb/tb_glitc_intercom_align.sv
// Bench for glitc_intercom_align: a deserializer model that rotates words on bitslip,
// an outcome-level reference model feeding a scoreboard, and a monitor that checks events.
module tb_glitc_intercom_align;

    localparam int         NUM_CH       = 2;
    localparam logic [3:0] PAT          = 4'b1000;
    localparam int         MATCH_COUNT  = 16;
    localparam int         BITSLIP_WAIT = 8;
    localparam int         MAX_SLIPS    = 7;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                train;
    logic [4*NUM_CH-1:0] data_i;
    logic [4*NUM_CH-1:0] data_o;
    logic [NUM_CH-1:0]   bitslip;
    logic [NUM_CH-1:0]   locked;
    logic [NUM_CH-1:0]   fail;
    logic                all_locked;
    logic [4*NUM_CH-1:0] slip_count;

    always #5 clk = ~clk;

    glitc_intercom_align #(
        .NUM_CH(NUM_CH), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MATCH_COUNT),
        .BITSLIP_WAIT(BITSLIP_WAIT), .MAX_SLIPS(MAX_SLIPS)
    ) dut (
        .sysclk_i(clk), .rst_n_i(rst_n), .train_i(train), .data_i(data_i),
        .data_o(data_o), .bitslip_o(bitslip), .locked_o(locked), .fail_o(fail),
        .all_locked_o(all_locked), .slip_count_o(slip_count)
    );

    typedef struct {
        int ch;
        int slips;
        bit lock;
    } exp_t;

    exp_t                expq[$];
    logic [4*NUM_CH-1:0] dq[$];
    int                  total = 0;
    int                  bad = 0;
    int                  cyc = 0;

    logic [3:0] base[NUM_CH];
    bit         override = 0;
    int         epoch = 0;
    int         seen_epoch = 0;
    int         rot[NUM_CH];
    int         pend[NUM_CH];

    int                npulse[NUM_CH];
    int                last_pulse[NUM_CH];
    logic [NUM_CH-1:0] prev_b = '0;
    logic [NUM_CH-1:0] prev_l = '0;
    logic [NUM_CH-1:0] prev_f = '0;
    logic              train_seen = 1'b0;

    function automatic logic [3:0] rotl(logic [3:0] w, int n);
        logic [3:0] r;
        r = w;
        for (int i = 0; i < n % 4; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Outcome of a training run: fewest left-rotations that reach the pattern, else failure.
    function automatic void model(int k, logic [3:0] w);
        for (int s = 0; s <= MAX_SLIPS; s++) begin
            if (rotl(w, s) == PAT) begin
                expq.push_back('{ch: k, slips: s, lock: 1'b1});
                return;
            end
        end
        expq.push_back('{ch: k, slips: MAX_SLIPS, lock: 1'b0});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic start_run(input bit do_push);
        train = 1'b0;
        epoch++;
        repeat (3) tick();
        train = 1'b1;
        if (do_push) for (int k = 0; k < NUM_CH; k++) model(k, base[k]);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (expq.size() > 0 && t < budget) begin
            tick();
            t++;
        end
        chk("drain_events", expq.size(), 0);
        expq.delete();
    endtask

    // Deserializer model: the word rotates left by one two cycles after each bitslip pulse.
    always @(posedge clk) begin
        #1;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            for (int k = 0; k < NUM_CH; k++) begin
                rot[k]  = 0;
                pend[k] = 0;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (pend[k] > 0) begin
                pend[k]--;
                if (pend[k] == 0) rot[k]++;
            end
            if (bitslip[k]) pend[k] = 2;
            data_i[4*k +: 4] = override ? 4'($urandom_range(0, 15)) : rotl(base[k], rot[k]);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dq.push_back(data_i);
    end

    always @(negedge clk) begin
        int  idx;
        exp_t e;
        if (dq.size() > 0) chk("data_o", data_o, dq.pop_front());
        if (!rst_n || (train && !train_seen))
            for (int k = 0; k < NUM_CH; k++) npulse[k] = 0;
        train_seen = train;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bitslip[k]) begin
                chk("bitslip_width", prev_b[k], 0);
                if (npulse[k] > 0)
                    chk("bitslip_gap_ok", 32'(cyc - last_pulse[k] >= BITSLIP_WAIT + 1), 1);
                npulse[k]++;
                last_pulse[k] = cyc;
            end
            if ((locked[k] && !prev_l[k]) || (fail[k] && !prev_f[k])) begin
                idx = -1;
                for (int i = 0; i < expq.size(); i++)
                    if (idx < 0 && expq[i].ch == k) idx = i;
                chk("event_expected", 32'(idx >= 0), 1);
                if (idx >= 0) begin
                    e = expq[idx];
                    expq.delete(idx);
                    chk("outcome_locked", locked[k], e.lock);
                    chk("outcome_fail", fail[k], !e.lock);
                    chk("slip_count", slip_count[4*k +: 4], e.slips);
                    chk("pulse_count", npulse[k], e.slips);
                end
            end
        end
        prev_b = bitslip;
        prev_l = locked;
        prev_f = fail;
    end

    initial begin
        int n;
        int t;
        rst_n = 1'b0;
        train = 1'b0;
        for (int k = 0; k < NUM_CH; k++) base[k] = PAT;
        repeat (3) tick();
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_all_locked", all_locked, 0);
        chk("rst_slip_count", slip_count, 0);
        rst_n = 1'b1;

        // Aligned lock, train first sampled at edge 10.
        wait_cyc(9);
        train = 1'b1;
        n = cyc + 1;
        for (int k = 0; k < NUM_CH; k++) model(k, base[k]);
        wait_cyc(n + MATCH_COUNT - 1);
        chk("aligned_early_lock", locked, 0);
        wait_cyc(n + MATCH_COUNT + 1);
        chk("aligned_locked", locked, 2'b11);
        chk("aligned_all_locked", all_locked, 1);
        chk("aligned_slip_count", slip_count, 0);
        drain(50);

        // Two-slip alignment on channel 0.
        base[0] = 4'b0010;
        base[1] = PAT;
        start_run(1);
        drain(400);
        chk("twoslip_count", slip_count[3:0], 2);
        chk("twoslip_locked", locked, 2'b11);

        // Failure on channel 1, then a restart clears it.
        base[0] = PAT;
        base[1] = 4'b0000;
        start_run(1);
        drain(400);
        chk("fail_flag", fail[1], 1);
        chk("fail_locked", locked[1], 0);
        chk("fail_slips", slip_count[7:4], 7);
        chk("fail_all_locked", all_locked, 0);
        train = 1'b0;
        tick();
        train = 1'b1;
        for (int k = 0; k < NUM_CH; k++) model(k, base[k]);
        tick();
        chk("fail_cleared", fail[1], 0);
        drain(400);

        // Sticky lock with corrupted data and train dropped, then relock.
        base[1] = PAT;
        start_run(1);
        drain(100);
        override = 1;
        train = 1'b0;
        repeat (20) begin
            tick();
            chk("sticky_lock", locked, 2'b11);
        end
        override = 0;
        repeat (2) tick();
        train = 1'b1;
        n = cyc + 1;
        for (int k = 0; k < NUM_CH; k++) model(k, base[k]);
        tick();
        chk("relock_drop", locked, 0);
        wait_cyc(n + MATCH_COUNT - 1);
        chk("relock_early", locked, 0);
        wait_cyc(n + MATCH_COUNT + 1);
        chk("relock_locked", locked, 2'b11);
        drain(50);

        // Abort during WAIT.
        base[0] = 4'b0010;
        start_run(0);
        t = 0;
        while (!bitslip[0] && t < 100) begin
            tick();
            t++;
        end
        chk("abort_saw_slip", bitslip[0], 1);
        repeat (3) tick();
        train = 1'b0;
        repeat (40) tick();
        chk("abort_slip_count", slip_count[3:0], 1);
        chk("abort_pulses", npulse[0], 1);
        chk("abort_locked", locked, 0);
        chk("abort_fail", fail, 0);

        // Reset during SLIP.
        base[0] = 4'b0000;
        start_run(0);
        t = 0;
        while (!bitslip[0] && t < 100) begin
            tick();
            t++;
        end
        chk("reset_saw_slip", bitslip[0], 1);
        rst_n = 1'b0;
        train = 1'b0;
        tick();
        chk("midrst_locked", locked, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_bitslip", bitslip, 0);
        chk("midrst_all_locked", all_locked, 0);
        chk("midrst_slip_count", slip_count, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_no_slip", bitslip, 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NUM_CH; k++)
                base[k] = ($urandom_range(0, 4) == 0) ? 4'b0000 : rotl(PAT, $urandom_range(0, 3));
            start_run(1);
            drain(500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
